// File: rtl/divider.sv
// divider: 8-bit unsigned restoring divider for the lab board.
// The dividend is loaded into Q, and the divisor is latched into D at START.
// Eight SHIFT/SUB iterations then leave the quotient in Q and the remainder in R.
// Each result nibble is also decoded onto a 7-segment display (active-low segments).
module divider (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ClrR_LdQ,
  input  logic       Execute,
  input  logic [7:0] SW,
  output logic [7:0] Qval,
  output logic [7:0] Rval,
  output logic       DivZero,
  output logic       Busy,
  output logic       Done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] q_r, q_s;
  logic [8:0] r_r, r_s;
  logic [7:0] d_r, d_s;
  logic [2:0] cnt_r, cnt_s;
  logic       divzero_r, divzero_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic [9:0] diff_s;

  // Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_driver(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Next-state and datapath logic; every register holds its value unless a state changes it.
  always_comb begin
    state_s   = state_r;
    q_s       = q_r;
    r_s       = r_r;
    d_s       = d_r;
    cnt_s     = cnt_r;
    divzero_s = divzero_r;
    // Trial subtraction is 10 bits wide, so bit 9 is the borrow (sign) bit.
    diff_s    = {1'b0, r_r} - {2'b00, d_r};
    case (state_r)
      IDLE: begin
        // A load takes priority, and Execute is not looked at in the same cycle.
        if (ClrR_LdQ) begin
          q_s       = SW;
          r_s       = 9'd0;
          divzero_s = 1'b0;
        end else if (Execute) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        d_s   = SW;
        cnt_s = 3'd0;
        if (SW == 8'h00) begin
          // Divide by zero: quotient saturates and the dividend becomes the remainder.
          divzero_s = 1'b1;
          r_s       = {1'b0, q_r};
          q_s       = 8'hFF;
          state_s   = DONE;
        end else begin
          divzero_s = 1'b0;
          state_s   = SHIFT;
        end
      end
      SHIFT: begin
        {r_s, q_s} = {r_r[7:0], q_r, 1'b0};
        state_s    = SUB;
      end
      SUB: begin
        if (!diff_s[9]) begin
          r_s = diff_s[8:0];
          q_s = {q_r[7:1], 1'b1};
        end else begin
          r_s = r_r;
          q_s = q_r;
        end
        cnt_s = cnt_r + 3'd1;
        if (cnt_r == 3'd7) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        // Execute must be released first, so that a held button runs only once.
        if (!Execute) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == START) || (state_s == SHIFT) || (state_s == SUB);
    done_s = (state_s == DONE);
  end

  // State, datapath and status registers, cleared immediately by Reset_n.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      q_r       <= 8'd0;
      r_r       <= 9'd0;
      d_r       <= 8'd0;
      cnt_r     <= 3'd0;
      divzero_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      q_r       <= q_s;
      r_r       <= r_s;
      d_r       <= d_s;
      cnt_r     <= cnt_s;
      divzero_r <= divzero_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign Qval    = q_r;
  assign Rval    = r_r[7:0];
  assign DivZero = divzero_r;
  assign Busy    = busy_r;
  assign Done    = done_r;
  assign HEX0    = hex_driver(q_r[3:0]);
  assign HEX1    = hex_driver(q_r[7:4]);
  assign HEX2    = hex_driver(r_r[3:0]);
  assign HEX3    = hex_driver(r_r[7:4]);

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed-vector bench for the divider, with hand-computed quotients and remainders.
module tb_divider;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       ClrR_LdQ = 1'b0;
  logic       Execute = 1'b0;
  logic [7:0] SW = 8'h00;
  logic [7:0] Qval, Rval;
  logic       DivZero, Busy, Done;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  int errors = 0;
  int checks = 0;

  divider dut (
    .Clk(Clk), .Reset_n(Reset_n), .ClrR_LdQ(ClrR_LdQ), .Execute(Execute), .SW(SW),
    .Qval(Qval), .Rval(Rval), .DivZero(DivZero), .Busy(Busy), .Done(Done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 Clk = ~Clk;

  // Inputs are driven, and outputs sampled, on the falling edge.
  // The task loads the dividend, runs one division and then releases Execute.
  // lat is the expected edge index (counted from the Execute sample) at which Done first appears.
  task automatic run_div(input logic [7:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input int lat, input int hold, input bit mid_clr, input string nm);
    int n;
    bit held_bad;
    @(negedge Clk);
    SW = dvd; ClrR_LdQ = 1'b1;
    @(negedge Clk);
    ClrR_LdQ = 1'b0;
    checks++;
    if (Qval !== dvd || Rval !== 8'h00) begin
      errors++; $display("FAIL %s_load: Q=%h R=%h expected Q=%h R=00", nm, Qval, Rval, dvd);
    end
    SW = dvs; Execute = 1'b1;
    @(negedge Clk);          // edge 0 passed, START
    n = 0;
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL %s_start: Busy=%b Done=%b expected Busy=1 Done=0", nm, Busy, Done);
    end
    @(negedge Clk);          // edge 1 passed; the divisor is now latched
    n = 1;
    SW = 8'hAA;
    while (!Done && n < 40) begin
      ClrR_LdQ = (mid_clr && n == 5);
      if (mid_clr && n == 5) SW = 8'h99;
      @(negedge Clk);
      n++;
    end
    ClrR_LdQ = 1'b0;
    checks++;
    if (n !== lat) begin
      errors++; $display("FAIL %s_latency: Done at edge %0d expected %0d", nm, n, lat);
    end
    checks++;
    if (Qval !== eq || Rval !== er) begin
      errors++; $display("FAIL %s_result: Q=%h R=%h expected Q=%h R=%h", nm, Qval, Rval, eq, er);
    end
    checks++;
    if (DivZero !== edz || Busy !== 1'b0) begin
      errors++; $display("FAIL %s_flags: DivZero=%b Busy=%b expected DivZero=%b Busy=0", nm, DivZero, Busy, edz);
    end
    held_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (Done !== 1'b1 || Busy !== 1'b0 || Qval !== eq || Rval !== er) held_bad = 1'b1;
    end
    checks++;
    if (held_bad !== 1'b0) begin
      errors++; $display("FAIL %s_hold: held=%b expected 0", nm, held_bad);
    end
    Execute = 1'b0;
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Qval !== eq || Rval !== er) begin
      errors++; $display("FAIL %s_idle: Done=%b Busy=%b Q=%h R=%h expected 0 0 %h %h", nm, Done, Busy, Qval, Rval, eq, er);
    end
  endtask

  task automatic test_reset();
    #12 Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Qval !== 8'h00 || Rval !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0) begin
      errors++; $display("FAIL reset: Q=%h R=%h B=%b D=%b Z=%b expected all 0", Qval, Rval, Busy, Done, DivZero);
    end
  endtask

  task automatic test_divide();
    run_div(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 17, 2, 1'b0, "d100_7");
    checks++;
    if (HEX1 !== 7'b1000000 || HEX0 !== 7'b0000110 || HEX3 !== 7'b1000000 || HEX2 !== 7'b0100100) begin
      errors++; $display("FAIL hex: HEX3..0=%b %b %b %b expected 1000000 0100100 1000000 0000110", HEX3, HEX2, HEX1, HEX0);
    end
    run_div(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 17, 1, 1'b0, "dFF_01");
    run_div(8'hFF, 8'h80, 8'h01, 8'h7F, 1'b0, 17, 1, 1'b0, "dFF_80");
    run_div(8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 17, 1, 1'b0, "d05_09");
  endtask

  task automatic test_div_zero();
    run_div(8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1, 1, 2, 1'b0, "dC8_00");
    run_div(8'hC8, 8'h0A, 8'h14, 8'h00, 1'b0, 17, 1, 1'b0, "dC8_0A");
  endtask

  task automatic test_held_execute();
    // 43 / 5 = 8 r 3. Execute is held about 60 cycles, and a load press arrives mid-run.
    run_div(8'h2B, 8'h05, 8'h08, 8'h03, 1'b0, 17, 40, 1'b1, "held");
  endtask

  task automatic test_reset_mid_run();
    @(negedge Clk);
    SW = 8'h64; ClrR_LdQ = 1'b1;
    @(negedge Clk);
    ClrR_LdQ = 1'b0; SW = 8'h07; Execute = 1'b1;
    repeat (9) @(negedge Clk);
    Reset_n = 1'b0; Execute = 1'b0;
    #1;
    checks++;
    if (Qval !== 8'h00 || Rval !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0 || HEX0 !== 7'b1000000) begin
      errors++; $display("FAIL midreset: Q=%h R=%h B=%b D=%b Z=%b H0=%b expected 0s", Qval, Rval, Busy, Done, DivZero, HEX0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL after_reset_idle: Busy=%b Done=%b expected 0 0", Busy, Done);
    end
    run_div(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 17, 1, 1'b0, "rerun");
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_held_execute();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
